shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier_pkg.sv | 12 +
 rtl/shift_add_multiplier_adder.sv | 23 ++
 rtl/shift_add_multiplier.sv | 94 +++++++++
 tb/tb_shift_add_multiplier.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// rtl/shift_add_multiplier_pkg.sv - shared state encoding for the shift-and-add multiplier
package shift_add_multiplier_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// rtl/shift_add_multiplier_adder.sv - ripple-carry adder used for each partial-product step
module adder #(
  parameter int BUS_WIDTH = 8
) (
  input  logic [BUS_WIDTH-1:0] i_a,
  input  logic [BUS_WIDTH-1:0] i_b,
  input  logic                 i_c,
  output logic [BUS_WIDTH-1:0] o_s,
  output logic                 o_c
);

  logic [BUS_WIDTH:0] carry;

  assign carry[0] = i_c;

  for (genvar k = 0; k < BUS_WIDTH; k++) begin : g_bit
    assign o_s[k]       = i_a[k] ^ i_b[k] ^ carry[k];
    assign carry[k + 1] = (i_a[k] & i_b[k]) | (carry[k] & (i_a[k] ^ i_b[k]));
  end

  assign o_c = carry[BUS_WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned multiplier, one partial product per cycle
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [BUS_WIDTH-1:0]     i_a,
  input  logic [BUS_WIDTH-1:0]     i_b,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [2*BUS_WIDTH-1:0]   o_p
);

  localparam int CW = $clog2(BUS_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BUS_WIDTH - 1);

  state_t               state_q;
  logic [BUS_WIDTH-1:0] mcand_q;
  logic [BUS_WIDTH-1:0] mplier_q;
  logic [BUS_WIDTH-1:0] mplier_d;
  logic [BUS_WIDTH:0]   acc_q;
  logic [BUS_WIDTH:0]   acc_d;
  logic [BUS_WIDTH:0]   addend;
  logic [BUS_WIDTH:0]   sum;
  logic                 sum_c;
  logic [CW-1:0]        cnt_q;

  assign addend = mplier_q[0] ? {1'b0, mcand_q} : '0;

  adder #(
    .BUS_WIDTH(BUS_WIDTH + 1)
  ) u_adder (
    .i_a(acc_q),
    .i_b(addend),
    .i_c(1'b0),
    .o_s(sum),
    .o_c(sum_c)
  );

  // The {sum, mplier} pair shifts right one place; sum_c is always 0 but keeps the shift exact.
  assign acc_d    = {sum_c, sum[BUS_WIDTH:1]};
  assign mplier_d = {sum[0], mplier_q[BUS_WIDTH-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_p      <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            mcand_q  <= i_a;
            mplier_q <= i_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= ST_RUN;
            o_busy   <= 1'b1;
            o_done   <= 1'b0;
          end else begin
            state_q  <= ST_IDLE;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
          end
        end
        ST_RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            o_p     <= {acc_d[BUS_WIDTH-1:0], mplier_d};
            state_q <= ST_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

  localparam int BW = 8;

  logic              clk;
  logic              i_rst;
  logic              i_start;
  logic [BW-1:0]     i_a;
  logic [BW-1:0]     i_b;
  logic              o_busy;
  logic              o_done;
  logic [2*BW-1:0]   o_p;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  shift_add_multiplier #(.BUS_WIDTH(BW)) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_a(i_a),
    .i_b(i_b),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_p(o_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: an operation is a W-cycle busy window then a one-cycle done carrying a*b.
  int              m_phase = 0;   // 0 idle, 1 busy, 2 done
  int              m_left  = 0;
  logic [2*BW-1:0] m_prod  = '0;
  logic [2*BW-1:0] m_p     = '0;
  bit              m_valid = 0;

  always @(posedge clk) begin
    if (i_rst) begin
      m_phase = 0;
      m_p     = '0;
      m_valid = 1;
    end else if (m_valid) begin
      if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_phase = 2;
          m_p     = m_prod;
        end
      end else if (i_start) begin
        m_prod  = i_a * i_b;
        m_left  = BW;
        m_phase = 1;
      end else begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_busy", 32'(o_busy), 32'(m_phase == 1));
      check("model_done", 32'(o_done), 32'(m_phase == 2));
      check("model_p", 32'(o_p), 32'(m_p));
      if (o_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [BW-1:0] a, input logic [BW-1:0] b, output int busy_cycles);
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    busy_cycles = o_busy ? 1 : 0;
  endtask

  task automatic wait_done(inout int busy_cycles, output int cycles);
    bit ok = 0;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cycles++;
      if (o_done) begin
        ok = 1;
        break;
      end
      if (o_busy) busy_cycles++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: got timeout expected o_done within 40 cycles");
    end
  endtask

  initial begin
    int bc;
    int cyc;
    int d0;
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    tick();
    tick();
    i_rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_p", 32'(o_p), 32'h0);
      check("idle_busy", 32'(o_busy), 32'h0);
      check("idle_done", 32'(o_done), 32'h0);
    end

    start_op(8'd13, 8'd11, bc);
    wait_done(bc, cyc);
    check("13x11_busy_cycles", 32'(bc), 32'd8);
    check("13x11_p", 32'(o_p), 32'h008F);
    repeat (4) tick();
    check("13x11_hold", 32'(o_p), 32'h008F);

    start_op(8'd255, 8'd255, bc);
    check("hold_during_run", 32'(o_p), 32'h008F);
    wait_done(bc, cyc);
    check("255x255_p", 32'(o_p), 32'hFE01);
    tick();

    start_op(8'd0, 8'd200, bc);
    wait_done(bc, cyc);
    check("0x200_p", 32'(o_p), 32'h0000);
    tick();

    d0 = done_cnt;
    start_op(8'd7, 8'd9, bc);
    tick();
    tick();
    i_a     = 8'd2;
    i_b     = 8'd2;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(bc, cyc);
    check("7x9_p", 32'(o_p), 32'h003F);
    repeat (12) tick();
    check("7x9_done_count", 32'(done_cnt - d0), 32'd1);

    start_op(8'd100, 8'd3, bc);
    repeat (3) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_done", 32'(o_done), 32'h0);
    check("rst_p", 32'(o_p), 32'h0);
    d0 = done_cnt;
    repeat (12) tick();
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    start_op(8'd5, 8'd5, bc);
    wait_done(bc, cyc);
    check("5x5_p", 32'(o_p), 32'h0019);
    tick();

    i_a     = 8'd6;
    i_b     = 8'd7;
    i_start = 1'b1;
    tick();
    i_a = 8'd12;
    i_b = 8'd12;
    wait_done(bc, cyc);
    check("b2b_first_p", 32'(o_p), 32'h002A);
    tick();
    check("b2b_no_idle", 32'(o_busy), 32'h1);
    i_start = 1'b0;
    wait_done(bc, cyc);
    check("b2b_spacing", 32'(cyc + 1), 32'd9);
    check("b2b_second_p", 32'(o_p), 32'h0090);
    tick();

    for (int n = 0; n < 60; n++) begin
      i_a     = BW'($urandom);
      i_b     = BW'($urandom);
      i_rst   = ($urandom_range(0, 19) == 0);
      i_start = 1'b1;
      repeat ($urandom_range(1, 12)) tick();
      i_rst   = 1'b0;
      i_start = 1'b0;
      repeat ($urandom_range(0, 10)) tick();
    end
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
